// File: rtl/cpu_mul_pkg.sv
// Shared types and helpers for the RV32M multiply sequencer.
package cpu_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_funct_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RELEASE = 3'd2,
    FIXUP   = 3'd3,
    DONE    = 3'd4
  } mul_state_t;

  // MULHSU rides on the unsigned product and MUL's low half ignores sign.
  function automatic logic mul_signed_class(input mul_funct_t funct);
    return (funct == MULH);
  endfunction

endpackage

// File: rtl/cpu_multiply_ctrl_if.sv
// Execute-side request bus plus multiplier latch/ready bus of the sequencer.
interface cpu_multiply_ctrl_if
  import cpu_mul_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              i_request;
  mul_funct_t        i_funct;
  logic [XLEN-1:0]   i_op1;
  logic [XLEN-1:0]   i_op2;
  logic              o_ready;
  logic [XLEN-1:0]   o_result;
  logic              o_mul_latch;
  logic              o_mul_signed;
  logic [XLEN-1:0]   o_mul_op1;
  logic [XLEN-1:0]   o_mul_op2;
  logic              i_mul_ready;
  logic [2*XLEN-1:0] i_mul_result;

  modport slave (
    input  i_request, i_funct, i_op1, i_op2, i_mul_ready, i_mul_result,
    output o_ready, o_result, o_mul_latch, o_mul_signed, o_mul_op1, o_mul_op2
  );

  modport master (
    output i_request, i_funct, i_op1, i_op2, i_mul_ready, i_mul_result,
    input  o_ready, o_result, o_mul_latch, o_mul_signed, o_mul_op1, o_mul_op2
  );
endinterface

// File: rtl/cpu_multiply_ctrl.sv
// Sequences RV32M multiplies onto a shared 2*XLEN multiplier, with a
// one-entry raw-product cache and a MULHSU correction cycle.
module cpu_multiply_ctrl
  import cpu_mul_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit CACHE_ENABLE = 1'b1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  cpu_multiply_ctrl_if.slave  bus
);

  mul_state_t        state_q,       state_d;
  mul_funct_t        funct_q,       funct_d;
  logic [XLEN-1:0]   op1_q,         op1_d;
  logic [XLEN-1:0]   op2_q,         op2_d;
  logic              cls_q,         cls_d;
  logic [2*XLEN-1:0] product_q,     product_d;
  logic [XLEN-1:0]   fix_hi_q,      fix_hi_d;
  logic [XLEN-1:0]   result_q,      result_d;
  logic              ready_q,       ready_d;
  logic              latch_q,       latch_d;
  logic              mul_signed_q,  mul_signed_d;
  logic [XLEN-1:0]   mul_op1_q,     mul_op1_d;
  logic [XLEN-1:0]   mul_op2_q,     mul_op2_d;
  logic              cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]   cache_op1_q,   cache_op1_d;
  logic [XLEN-1:0]   cache_op2_q,   cache_op2_d;
  logic              cache_cls_q,   cache_cls_d;

  logic req_cls_s;
  logic hit_s;

  assign req_cls_s = mul_signed_class(bus.i_funct);
  assign hit_s     = (CACHE_ENABLE == 1'b1) && cache_valid_q
                     && (bus.i_op1 == cache_op1_q) && (bus.i_op2 == cache_op2_q)
                     && (req_cls_s == cache_cls_q);

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    funct_d       = funct_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    cls_d         = cls_q;
    product_d     = product_q;
    fix_hi_d      = fix_hi_q;
    result_d      = result_q;
    ready_d       = 1'b0;
    latch_d       = 1'b0;
    mul_signed_d  = mul_signed_q;
    mul_op1_d     = mul_op1_q;
    mul_op2_d     = mul_op2_q;
    cache_valid_d = cache_valid_q;
    cache_op1_d   = cache_op1_q;
    cache_op2_d   = cache_op2_q;
    cache_cls_d   = cache_cls_q;

    case (state_q)
      IDLE: begin
        if (bus.i_request) begin
          funct_d = bus.i_funct;
          op1_d   = bus.i_op1;
          op2_d   = bus.i_op2;
          cls_d   = req_cls_s;
          if (hit_s) begin
            // A cached MULHSU still needs its correction applied.
            state_d = (bus.i_funct == MULHSU) ? FIXUP : DONE;
          end else begin
            state_d      = ISSUE;
            latch_d      = 1'b1;
            mul_signed_d = req_cls_s;
            mul_op1_d    = bus.i_op1;
            mul_op2_d    = bus.i_op2;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (bus.i_mul_ready) begin
          product_d     = bus.i_mul_result;
          cache_valid_d = 1'b1;
          cache_op1_d   = op1_q;
          cache_op2_d   = op2_q;
          cache_cls_d   = cls_q;
          state_d       = RELEASE;
        end else begin
          latch_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.i_mul_ready) begin
          state_d = (funct_q == MULHSU) ? FIXUP : DONE;
        end else begin
          state_d = RELEASE;
        end
      end
      FIXUP: begin
        if (op1_q[XLEN-1]) begin
          fix_hi_d = product_q[2*XLEN-1:XLEN] - op2_q;
        end else begin
          fix_hi_d = product_q[2*XLEN-1:XLEN];
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.i_request) begin
          ready_d = 1'b1;
          case (funct_q)
            MUL:     result_d = product_q[XLEN-1:0];
            MULHSU:  result_d = fix_hi_q;
            default: result_d = product_q[2*XLEN-1:XLEN];
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      funct_q       <= MUL;
      op1_q         <= {XLEN{1'b0}};
      op2_q         <= {XLEN{1'b0}};
      cls_q         <= 1'b0;
      product_q     <= {(2*XLEN){1'b0}};
      fix_hi_q      <= {XLEN{1'b0}};
      result_q      <= {XLEN{1'b0}};
      ready_q       <= 1'b0;
      latch_q       <= 1'b0;
      mul_signed_q  <= 1'b0;
      mul_op1_q     <= {XLEN{1'b0}};
      mul_op2_q     <= {XLEN{1'b0}};
      cache_valid_q <= 1'b0;
      cache_op1_q   <= {XLEN{1'b0}};
      cache_op2_q   <= {XLEN{1'b0}};
      cache_cls_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      funct_q       <= funct_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      cls_q         <= cls_d;
      product_q     <= product_d;
      fix_hi_q      <= fix_hi_d;
      result_q      <= result_d;
      ready_q       <= ready_d;
      latch_q       <= latch_d;
      mul_signed_q  <= mul_signed_d;
      mul_op1_q     <= mul_op1_d;
      mul_op2_q     <= mul_op2_d;
      cache_valid_q <= cache_valid_d;
      cache_op1_q   <= cache_op1_d;
      cache_op2_q   <= cache_op2_d;
      cache_cls_q   <= cache_cls_d;
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_result     = result_q;
  assign bus.o_mul_latch  = latch_q;
  assign bus.o_mul_signed = mul_signed_q;
  assign bus.o_mul_op1    = mul_op1_q;
  assign bus.o_mul_op2    = mul_op2_q;

endmodule

// File: tb/tb_cpu_multiply_ctrl.sv
// Directed plus randomized bench for cpu_multiply_ctrl, with and without cache.
module tb_cpu_multiply_ctrl;
  import cpu_mul_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_multiply_ctrl_if #(.XLEN(XLEN)) bus ();
  cpu_multiply_ctrl_if #(.XLEN(XLEN)) bus_nc ();

  cpu_multiply_ctrl #(.XLEN(XLEN), .CACHE_ENABLE(1'b1)) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus.slave)
  );
  cpu_multiply_ctrl #(.XLEN(XLEN), .CACHE_ENABLE(1'b0)) dut_nc (
    .i_clock(clk), .i_reset(rst), .bus(bus_nc.slave)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int mul_lat = 0;
  int latch_cnt = 0;
  int latch_cnt_nc = 0;
  logic latch_prev = 1'b0;
  logic latch_prev_nc = 1'b0;
  logic last_sgn = 1'b0;

  logic        ref_valid = 1'b0;
  logic [31:0] ref_a = 32'd0;
  logic [31:0] ref_b = 32'd0;
  logic        ref_cls = 1'b0;

  // Behavioural multiplier: full-width product of (optionally sign-extended) operands.
  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Architectural RV32M result.
  function automatic logic [31:0] rv_expect(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Multiplier models for both buses
  always @(negedge clk) begin
    static int mcnt = 0;
    if (rst || !bus.o_mul_latch) begin
      bus.i_mul_ready = 1'b0;
      mcnt = 0;
    end else if (!bus.i_mul_ready) begin
      if (mcnt >= mul_lat) begin
        bus.i_mul_ready  = 1'b1;
        bus.i_mul_result = mul_model(bus.o_mul_op1, bus.o_mul_op2, bus.o_mul_signed);
      end else begin
        mcnt++;
      end
    end
  end

  always @(negedge clk) begin
    static int ncnt = 0;
    if (rst || !bus_nc.o_mul_latch) begin
      bus_nc.i_mul_ready = 1'b0;
      ncnt = 0;
    end else if (!bus_nc.i_mul_ready) begin
      if (ncnt >= mul_lat) begin
        bus_nc.i_mul_ready  = 1'b1;
        bus_nc.i_mul_result = mul_model(bus_nc.o_mul_op1, bus_nc.o_mul_op2, bus_nc.o_mul_signed);
      end else begin
        ncnt++;
      end
    end
  end

  // Count latch pulses
  always @(negedge clk) begin
    latch_prev    <= bus.o_mul_latch;
    latch_prev_nc <= bus_nc.o_mul_latch;
    if (bus.o_mul_latch && !latch_prev) begin
      latch_cnt <= latch_cnt + 1;
      last_sgn  <= bus.o_mul_signed;
    end
    if (bus_nc.o_mul_latch && !latch_prev_nc) latch_cnt_nc <= latch_cnt_nc + 1;
  end

  task automatic run_txn(input bit nc, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input string tag, output logic [31:0] res);
    bit   hit;
    int   c0;
    int   cyc;
    logic got;
    logic cls;
    cls = (f == 2'b01);
    hit = !nc && ref_valid && (a == ref_a) && (b == ref_b) && (cls == ref_cls);
    c0  = nc ? latch_cnt_nc : latch_cnt;
    if (nc) begin
      bus_nc.i_funct = mul_funct_t'(f); bus_nc.i_op1 = a; bus_nc.i_op2 = b;
      bus_nc.i_request = 1'b1;
    end else begin
      bus.i_funct = mul_funct_t'(f); bus.i_op1 = a; bus.i_op2 = b;
      bus.i_request = 1'b1;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = nc ? bus_nc.o_ready : bus.o_ready;
    end
    check({tag, "_ready"}, 64'(got), 64'd1);
    res = nc ? bus_nc.o_result : bus.o_result;
    check({tag, "_result"}, 64'(res), 64'(rv_expect(f, a, b)));
    if (hit && f != 2'b10) check({tag, "_hitlat"}, 64'(cyc), 64'd2);
    if (nc) bus_nc.i_request = 1'b0; else bus.i_request = 1'b0;
    @(negedge clk);
    got = nc ? bus_nc.o_ready : bus.o_ready;
    check({tag, "_drop"}, 64'(got), 64'd0);
    check({tag, "_latches"}, 64'((nc ? latch_cnt_nc : latch_cnt) - c0), hit ? 64'd0 : 64'd1);
    if (!nc && !hit) begin
      check({tag, "_signed"}, 64'(last_sgn), 64'(cls));
      ref_valid = 1'b1; ref_a = a; ref_b = b; ref_cls = cls;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] pool [4];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rf;
    int c0;
    int nrdy;
    pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;

    bus.i_request = 1'b0; bus.i_funct = MUL; bus.i_op1 = 32'd0; bus.i_op2 = 32'd0;
    bus.i_mul_ready = 1'b0; bus.i_mul_result = 64'd0;
    bus_nc.i_request = 1'b0; bus_nc.i_funct = MUL; bus_nc.i_op1 = 32'd0; bus_nc.i_op2 = 32'd0;
    bus_nc.i_mul_ready = 1'b0; bus_nc.i_mul_result = 64'd0;

    repeat (3) @(negedge clk);
    check("rst_ready",  64'(bus.o_ready), 64'd0);
    check("rst_result", 64'(bus.o_result), 64'd0);
    check("rst_latch",  64'(bus.o_mul_latch), 64'd0);
    check("rst_signed", 64'(bus.o_mul_signed), 64'd0);
    check("rst_ops",    {bus.o_mul_op1, bus.o_mul_op2}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 2'b00, 32'd111, 32'd222, "mul_cold", res);
    check("mul_cold_const", 64'(res), 64'd24642);
    run_txn(1'b0, 2'b11, 32'd111, 32'd222, "mulhu_hit", res);
    check("mulhu_hit_const", 64'(res), 64'd0);
    run_txn(1'b0, 2'b01, 32'hFFFF_FFFE, 32'd3, "mulh_neg", res);
    check("mulh_neg_const", 64'(res), 64'h0000_0000_FFFF_FFFF);
    run_txn(1'b0, 2'b00, 32'hFFFF_FFFE, 32'd3, "mul_cls_miss", res);
    check("mul_cls_miss_const", 64'(res), 64'h0000_0000_FFFF_FFFA);
    run_txn(1'b0, 2'b10, 32'hFFFF_FFFF, 32'd2, "mulhsu_fix", res);
    check("mulhsu_fix_const", 64'(res), 64'h0000_0000_FFFF_FFFF);
    run_txn(1'b0, 2'b11, 32'hFFFF_FFFF, 32'd2, "mulhu_raw", res);
    check("mulhu_raw_const", 64'(res), 64'd1);
    run_txn(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max", res);
    check("mulhu_max_const", 64'(res), 64'h0000_0000_FFFF_FFFE);
    run_txn(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "nc_first", res);
    run_txn(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "nc_repeat", res);

    // Reset while the multiplier is still busy.
    mul_lat = 20;
    bus.i_funct = MUL; bus.i_op1 = 32'd7; bus.i_op2 = 32'd9; bus.i_request = 1'b1;
    for (int i = 0; i < 10 && !bus.o_mul_latch; i++) @(negedge clk);
    check("rst_mid_issue_seen", 64'(bus.o_mul_latch), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_latch", 64'(bus.o_mul_latch), 64'd0);
    check("rst_mid_ready", 64'(bus.o_ready), 64'd0);
    bus.i_request = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_valid = 1'b0;
    mul_lat = 1;
    @(negedge clk);
    run_txn(1'b0, 2'b00, 32'd7, 32'd9, "after_rst", res);

    // Request withdrawn before o_ready: transaction completes silently.
    c0 = latch_cnt;
    bus.i_funct = MULHU; bus.i_op1 = 32'h1234_5678; bus.i_op2 = 32'h9ABC_DEF0;
    bus.i_request = 1'b1;
    @(negedge clk);
    bus.i_request = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_ready) nrdy++;
    end
    check("early_noready", 64'(nrdy), 64'd0);
    check("early_latch", 64'(latch_cnt - c0), 64'd1);
    ref_valid = 1'b1; ref_a = 32'h1234_5678; ref_b = 32'h9ABC_DEF0; ref_cls = 1'b0;
    run_txn(1'b0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, "early_hit", res);

    // Randomized traffic; operand reuse provokes cache hits.
    ra = 32'd5; rb = 32'd6;
    for (int n = 0; n < 150; n++) begin
      mul_lat = int'($urandom_range(0, 3));
      rf = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        ra = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 3)];
        rb = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 3)];
      end
      run_txn((n % 5) == 4, rf, ra, rb, $sformatf("rnd%0d", n), res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
